// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a request/grant + beat-stream line refill FSM.
// Lookup is combinational; a miss stalls fetch until the latched line has been refilled.
module icache_refill #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned LINES      = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [31:0]       i_fetch_addr,
   input  logic              i_fetch_en,
   input  logic              i_flush,
   output logic [31:0]       o_instr_c,
   output logic              o_imiss_c,
   output logic              o_mem_req,
   output logic [31:0]       o_mem_addr,
   input  logic              i_mem_gnt,
   input  logic              i_mem_valid,
   input  logic [31:0]       i_mem_data,
   output logic [CNT_W-1:0]  o_miss_count
);

   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = 32 - OFF_W - IDX_W - 2;
   localparam int unsigned AW    = IDX_W + OFF_W;
   localparam int unsigned DEPTH = LINES * LINE_WORDS;
   localparam int unsigned LSB_W = OFF_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LINES-1:0]     r_valid;
   logic [TAG_W-1:0]     r_tag  [LINES];
   logic [31:0]          r_data [DEPTH];
   logic [31:0]          r_line_addr;
   logic [OFF_W-1:0]     r_cnt;
   logic                 r_mem_req;
   logic                 r_kill;
   logic [CNT_W-1:0]     r_miss_cnt;

   logic [OFF_W-1:0]     w_off;
   logic [IDX_W-1:0]     w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic [IDX_W-1:0]     w_line_idx;
   logic [TAG_W-1:0]     w_line_tag;
   logic [AW-1:0]        w_rd_ptr;
   logic [AW-1:0]        w_wr_ptr;
   logic                 w_hit;
   logic                 w_start;
   logic                 w_gnt;
   logic                 w_beat;
   logic                 w_last;
   logic                 w_unused_ok;

   assign w_off       = i_fetch_addr[OFF_W+1:2];
   assign w_idx       = i_fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_tag       = i_fetch_addr[31:OFF_W+IDX_W+2];
   assign w_line_idx  = r_line_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_line_tag  = r_line_addr[31:OFF_W+IDX_W+2];
   assign w_rd_ptr    = {w_idx, w_off};
   assign w_wr_ptr    = {w_line_idx, r_cnt};
   assign w_unused_ok = ^i_fetch_addr[1:0];

   assign w_hit = i_fetch_en & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);

   assign o_mem_req    = r_mem_req;
   assign o_mem_addr   = r_line_addr;
   assign o_miss_count = r_miss_cnt;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state, lookup result and per-cycle control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_gnt       = 1'b0;
      w_beat      = 1'b0;
      w_last      = 1'b0;
      o_instr_c   = 32'h0;
      o_imiss_c   = (i_fetch_en & ~w_hit) | (r_state != S_IDLE);
      if (w_hit) o_instr_c = r_data[w_rd_ptr];
      case (r_state)
         S_IDLE: begin
            if (i_fetch_en && !w_hit && !i_flush) begin
               w_start     = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (i_mem_gnt) begin
               w_gnt       = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            if (i_mem_valid) begin
               w_beat = 1'b1;
               if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Refill bookkeeping: line address, beat counter, request, kill flag, miss counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_line_addr <= 32'h0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_kill      <= 1'b0;
         r_miss_cnt  <= '0;
      end else begin
         if (w_start) begin
            r_line_addr <= {i_fetch_addr[31:LSB_W], LSB_W'(0)};
            r_mem_req   <= 1'b1;
            if (!(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
         if (w_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
         end
         if (w_beat) r_cnt <= r_cnt + OFF_W'(1);
         if (w_last)                                r_kill <= 1'b0;
         else if (i_flush && (r_state != S_IDLE))   r_kill <= 1'b1;
      end
   end

   // Valid bits: a flush always wins over a line completing on the same edge
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                r_valid <= '0;
      else if (i_flush)            r_valid <= '0;
      else if (w_last && !r_kill)  r_valid[w_line_idx] <= 1'b1;
   end

   // Data and tag storage carry no reset
   always_ff @(posedge i_clk) begin
      if (w_beat) r_data[w_wr_ptr]  <= i_mem_data;
      if (w_last) r_tag[w_line_idx] <= w_line_tag;
   end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: vector table for fill/hit/conflict plus sequences
// for memory stalls, flush, fetch-address changes, async reset and counter saturation.
module tb_icache_refill;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] fetch_addr;
   logic        fetch_en, flush, mem_gnt, mem_valid;
   logic [31:0] mem_data;
   logic [31:0] instr, mem_addr;
   logic        imiss, mem_req;
   logic [15:0] miss_count;

   logic [31:0] s_addr, s_instr, s_mem_addr, s_data;
   logic        s_en, s_flush, s_gnt, s_valid, s_imiss, s_req;
   logic [2:0]  s_count;

   int n_vec = 0;
   int n_bad = 0;

   icache_refill u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_fetch_addr(fetch_addr), .i_fetch_en(fetch_en),
      .i_flush(flush), .o_instr_c(instr), .o_imiss_c(imiss), .o_mem_req(mem_req),
      .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt), .i_mem_valid(mem_valid),
      .i_mem_data(mem_data), .o_miss_count(miss_count)
   );

   icache_refill #(.LINE_WORDS(2), .LINES(4), .CNT_W(3)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_fetch_addr(s_addr), .i_fetch_en(s_en),
      .i_flush(s_flush), .o_instr_c(s_instr), .o_imiss_c(s_imiss), .o_mem_req(s_req),
      .o_mem_addr(s_mem_addr), .i_mem_gnt(s_gnt), .i_mem_valid(s_valid),
      .i_mem_data(s_data), .o_miss_count(s_count)
   );

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic        gnt;
      logic        mv;
      logic [31:0] md;
      logic        ex_imiss;
      logic [31:0] ex_instr;
      logic        ex_req;
      logic [31:0] ex_maddr;
      logic [15:0] ex_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, input logic [31:0] addr, input logic gnt, input logic mv,
                      input logic [31:0] md, input logic ex_imiss, input logic [31:0] ex_instr,
                      input logic ex_req, input logic [31:0] ex_maddr, input logic [15:0] ex_cnt);
      vec_t v;
      v.en = en; v.addr = addr; v.gnt = gnt; v.mv = mv; v.md = md;
      v.ex_imiss = ex_imiss; v.ex_instr = ex_instr; v.ex_req = ex_req;
      v.ex_maddr = ex_maddr; v.ex_cnt = ex_cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before sampling
   task automatic cyc(input logic en, input logic [31:0] addr, input logic fl, input logic g,
                      input logic v, input logic [31:0] d);
      @(negedge clk);
      fetch_en = en; fetch_addr = addr; flush = fl; mem_gnt = g; mem_valid = v; mem_data = d;
      #1;
   endtask

   task automatic fill4(input logic [31:0] addr, input logic [31:0] base);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, addr, 1'b0, 1'b0, 1'b1, base + 32'(i));
         chk("fill_imiss", {31'h0, imiss}, 32'h1);
      end
   endtask

   initial begin
      rst_n = 1'b0; fetch_en = 0; fetch_addr = 0; flush = 0; mem_gnt = 0; mem_valid = 0; mem_data = 0;
      s_en = 0; s_addr = 0; s_flush = 0; s_gnt = 0; s_valid = 0; s_data = 0;

      //   en addr     gnt mv data        | imiss instr   req maddr    cnt
      add(0, 32'h000, 0, 0, 32'h0,         0, 32'h0,   0, 32'h000, 0);
      add(1, 32'h100, 0, 0, 32'h0,         1, 32'h0,   0, 32'h000, 0);
      add(1, 32'h100, 0, 0, 32'h0,         1, 32'h0,   1, 32'h100, 1);
      add(1, 32'h100, 1, 0, 32'h0,         1, 32'h0,   1, 32'h100, 1);
      add(1, 32'h100, 0, 1, 32'hA0,        1, 32'h0,   0, 32'h100, 1);
      add(1, 32'h100, 0, 1, 32'hA1,        1, 32'h0,   0, 32'h100, 1);
      add(1, 32'h100, 0, 1, 32'hA2,        1, 32'h0,   0, 32'h100, 1);
      add(1, 32'h100, 0, 1, 32'hA3,        1, 32'h0,   0, 32'h100, 1);
      add(1, 32'h100, 0, 1, 32'hBAD,       0, 32'hA0,  0, 32'h100, 1);
      add(1, 32'h10C, 0, 0, 32'h0,         0, 32'hA3,  0, 32'h100, 1);
      add(1, 32'h108, 0, 0, 32'h0,         0, 32'hA2,  0, 32'h100, 1);
      add(1, 32'h500, 0, 0, 32'h0,         1, 32'h0,   0, 32'h100, 1);
      add(1, 32'h500, 1, 0, 32'h0,         1, 32'h0,   1, 32'h500, 2);
      add(1, 32'h500, 0, 1, 32'hB0,        1, 32'h0,   0, 32'h500, 2);
      add(1, 32'h500, 0, 1, 32'hB1,        1, 32'h0,   0, 32'h500, 2);
      add(1, 32'h500, 0, 1, 32'hB2,        1, 32'h0,   0, 32'h500, 2);
      add(1, 32'h500, 0, 1, 32'hB3,        1, 32'h0,   0, 32'h500, 2);
      add(1, 32'h504, 0, 0, 32'h0,         0, 32'hB1,  0, 32'h500, 2);
      add(1, 32'h100, 0, 0, 32'h0,         1, 32'h0,   0, 32'h500, 2);
      add(1, 32'h100, 1, 1, 32'hDEAD,      1, 32'h0,   1, 32'h100, 3);
      add(1, 32'h100, 0, 1, 32'hC0,        1, 32'h0,   0, 32'h100, 3);
      add(1, 32'h100, 0, 1, 32'hC1,        1, 32'h0,   0, 32'h100, 3);
      add(1, 32'h100, 0, 1, 32'hC2,        1, 32'h0,   0, 32'h100, 3);
      add(1, 32'h100, 0, 1, 32'hC3,        1, 32'h0,   0, 32'h100, 3);
      add(1, 32'h108, 0, 0, 32'h0,         0, 32'hC2,  0, 32'h100, 3);
      add(1, 32'h100, 0, 0, 32'h0,         0, 32'hC0,  0, 32'h100, 3);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         cyc(vecs[i].en, vecs[i].addr, 1'b0, vecs[i].gnt, vecs[i].mv, vecs[i].md);
         chk($sformatf("v%0d_imiss", i), {31'h0, imiss},   {31'h0, vecs[i].ex_imiss});
         chk($sformatf("v%0d_instr", i), instr,            vecs[i].ex_instr);
         chk($sformatf("v%0d_req", i),   {31'h0, mem_req}, {31'h0, vecs[i].ex_req});
         chk($sformatf("v%0d_maddr", i), mem_addr,         vecs[i].ex_maddr);
         chk($sformatf("v%0d_cnt", i),   {16'h0, miss_count}, {16'h0, vecs[i].ex_cnt});
      end

      // Memory stalls: late grant and idle cycles between beats
      cyc(1, 32'h300, 0, 0, 0, 0);
      chk("stall_miss", {31'h0, imiss}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 32'h300, 0, 0, 0, 0);
         chk("stall_req", {31'h0, mem_req}, 32'h1);
         chk("stall_maddr", mem_addr, 32'h300);
         chk("stall_imiss", {31'h0, imiss}, 32'h1);
      end
      cyc(1, 32'h300, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 32'h300, 0, 0, 1, 32'hD0 + 32'(i));
         chk("stall_beat_imiss", {31'h0, imiss}, 32'h1);
         if (i < 3) begin
            for (int j = 0; j < 2; j++) begin
               cyc(1, 32'h300, 0, 0, 0, 32'hFFFF);
               chk("stall_wait_imiss", {31'h0, imiss}, 32'h1);
            end
         end
      end
      cyc(1, 32'h304, 0, 0, 0, 0);
      chk("stall_d1", instr, 32'hD1);
      cyc(1, 32'h30C, 0, 0, 0, 0);
      chk("stall_d3", instr, 32'hD3);
      chk("stall_cnt", {16'h0, miss_count}, 32'd4);

      // Flush during the third beat leaves the refilled line invalid
      cyc(1, 32'h400, 0, 0, 0, 0);
      cyc(1, 32'h400, 0, 1, 0, 0);
      cyc(1, 32'h400, 0, 0, 1, 32'hE0);
      cyc(1, 32'h400, 0, 0, 1, 32'hE1);
      cyc(1, 32'h400, 1, 0, 1, 32'hE2);
      cyc(1, 32'h400, 0, 0, 1, 32'hE3);
      cyc(1, 32'h400, 0, 0, 0, 0);
      chk("kill_remiss", {31'h0, imiss}, 32'h1);
      chk("kill_idle_req", {31'h0, mem_req}, 32'h0);
      cyc(1, 32'h400, 0, 1, 0, 0);
      chk("kill_req2", {31'h0, mem_req}, 32'h1);
      chk("kill_cnt", {16'h0, miss_count}, 32'd6);
      fill4(32'h400, 32'hE0);
      cyc(1, 32'h404, 0, 0, 0, 0);
      chk("kill_refilled", instr, 32'hE1);

      // Flush in IDLE, then a miss coincident with flush does not start a refill
      cyc(0, 32'h404, 1, 0, 0, 0);
      cyc(1, 32'h404, 1, 0, 0, 0);
      chk("iflush_miss", {31'h0, imiss}, 32'h1);
      cyc(1, 32'h404, 0, 0, 0, 0);
      chk("iflush_noreq", {31'h0, mem_req}, 32'h0);
      chk("iflush_cnt", {16'h0, miss_count}, 32'd6);
      cyc(1, 32'h404, 0, 1, 0, 0);
      chk("iflush_req", {31'h0, mem_req}, 32'h1);
      fill4(32'h404, 32'hF0);
      cyc(1, 32'h408, 0, 0, 0, 0);
      chk("iflush_data", instr, 32'hF2);

      // Fetch address moves mid-refill; the latched line still completes
      cyc(1, 32'h180, 0, 0, 0, 0);
      cyc(1, 32'h180, 0, 1, 0, 0);
      cyc(1, 32'h180, 0, 0, 1, 32'h60);
      cyc(1, 32'h180, 0, 0, 1, 32'h61);
      cyc(1, 32'h200, 0, 0, 1, 32'h62);
      chk("move_imiss", {31'h0, imiss}, 32'h1);
      cyc(1, 32'h200, 0, 0, 1, 32'h63);
      cyc(1, 32'h200, 0, 0, 0, 0);
      chk("move_miss200", {31'h0, imiss}, 32'h1);
      cyc(1, 32'h200, 0, 1, 0, 0);
      chk("move_req200", mem_addr, 32'h200);
      chk("move_cnt", {16'h0, miss_count}, 32'd9);
      fill4(32'h200, 32'h70);
      cyc(1, 32'h184, 0, 0, 0, 0);
      chk("move_old_line", instr, 32'h61);
      cyc(1, 32'h20C, 0, 0, 0, 0);
      chk("move_new_line", instr, 32'h73);

      // Asynchronous reset in the middle of a refill
      cyc(1, 32'h240, 0, 0, 0, 0);
      cyc(1, 32'h240, 0, 1, 0, 0);
      cyc(1, 32'h240, 0, 0, 1, 32'h80);
      chk("rst_pre_req", {31'h0, mem_req}, 32'h0);
      chk("rst_pre_imiss", {31'h0, imiss}, 32'h1);
      #2;
      rst_n = 1'b0; fetch_en = 1'b0; mem_valid = 1'b0;
      #1;
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_imiss", {31'h0, imiss}, 32'h0);
      chk("rst_cnt", {16'h0, miss_count}, 32'h0);
      chk("rst_maddr", mem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      fetch_en = 1'b1;
      fetch_addr = 32'h100; #1; chk("post_rst_100", {31'h0, imiss}, 32'h1);
      fetch_addr = 32'h504; #1; chk("post_rst_504", {31'h0, imiss}, 32'h1);
      fetch_addr = 32'h30C; #1; chk("post_rst_30C", {31'h0, imiss}, 32'h1);
      fetch_addr = 32'h184; #1; chk("post_rst_184", instr, 32'h0);
      fetch_en = 1'b0;

      // Miss counter saturation on a narrow-counter instance
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk); s_en = 1; s_addr = 32'(k) << 12;
         @(negedge clk); s_en = 0; s_gnt = 1;
         @(negedge clk); s_gnt = 0; s_valid = 1; s_data = 32'(k);
         @(negedge clk);
         @(negedge clk); s_valid = 0;
         #1;
         chk($sformatf("sat_k%0d", k), {29'h0, s_count}, (k < 7) ? 32'(k) : 32'd7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Direct-mapped instruction cache with a line-refill state machine. It sits directly upstream of the fetch stage: it takes the fetch address, returns the instruction word, and raises the miss signal the hazard unit uses to stall PC and IF/ID. On a miss it fetches a whole line from the memory side through a request/grant handshake followed by a data-beat stream.

Parameters:
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
LINES, 64, number of lines; power of two.
CNT_W, 16, width of the miss counter.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  asynchronous, active-low reset.
FetchAddr  in  32  byte address of the instruction being fetched; bits [1:0] ignored.
FetchEn  in  1  a lookup is requested this cycle.
Flush  in  1  one-cycle pulse that invalidates the entire cache.
Instr  out  32  instruction word; 32'h0 when not a hit.
Imiss  out  1  fetch must stall this cycle.
MemReq  out  1  line-read request to memory.
MemAddr  out  32  line-aligned byte address of the requested line.
MemGnt  in  1  memory accepts the request.
MemValid  in  1  MemData carries the next word of the line.
MemData  in  32  refill data beat.
MissCount  out  CNT_W  saturating count of misses that started a refill.

Behaviour:
- Address split: offset = FetchAddr[log2(LINE_WORDS)+1:2]; index = the next log2(LINES) bits; tag = the remaining upper bits.
- Lookup is combinational in the same cycle.
  - hit = FetchEn & valid[index] & (tag_mem[index] == tag) & (state == IDLE).
  - Instr = data[index][offset] when hit, else 32'h0.
- Imiss = (FetchEn & ~hit) | (state != IDLE).
- Reset (Rst low, asynchronous):
  - state = IDLE; all valid bits cleared; MemReq = 0; MemAddr = 0; word counter = 0; MissCount = 0; kill flag = 0.
  - Data and tag arrays are not reset.
- FSM states: IDLE, REQ, FILL.
  - IDLE: when FetchEn & ~hit & ~Flush, latch the line address {FetchAddr[31:offset_msb+1], zeros}, increment MissCount (saturating at all-ones), and go to REQ on the next edge.
  - REQ: MemReq = 1 and MemAddr = latched address; both held stable until MemGnt. On MemGnt, go to FILL with counter = 0.
  - FILL: MemReq = 0. Each cycle with MemValid, write MemData to data[latched index][counter] and increment the counter. Cycles without MemValid are wait states with no change.
  - On the beat where counter == LINE_WORDS-1: write tag, set valid unless the kill flag is set, clear the kill flag, return to IDLE.
  - The re-lookup in the following cycle hits, so minimum miss latency = 2 + LINE_WORDS cycles with zero-wait memory.
- FetchAddr changes during REQ/FILL are ignored. The refill always completes for the latched line; Imiss stays high until IDLE, then the current FetchAddr is looked up again.
- Flush:
  - In any state, clears all valid bits on that edge.
  - In REQ or FILL, also sets the kill flag. The memory transaction still completes (no abort on the bus), but the refilled line is left invalid.
  - Flush in IDLE with a coincident miss does not start a refill that cycle.
- The counter wraps only via the return to IDLE. MemValid in IDLE or REQ is ignored.
- FetchEn = 0 in IDLE: Imiss = 0, no state change.

Test Plan:
- Reset then FetchEn=1, FetchAddr=0x100: Imiss=1 and Instr=0. MemReq asserts next cycle with MemAddr=0x100. MemGnt, then 4 back-to-back beats 0xA0..0xA3: next cycle Imiss=0, Instr=0xA0. FetchAddr=0x10C gives 0xA3 with no MemReq. MissCount=1.
- Memory stalls: MemGnt delayed 3 cycles and 2 idle cycles inserted between beats -> MemReq/MemAddr held stable; Imiss stays 1 throughout; data correct afterwards.
- Conflict: fill 0x100, then fetch 0x100+LINES*16 (same index, new tag) -> miss and refill. Re-fetching 0x100 then misses again. MissCount=3.
- Flush pulse during FILL beat 2 -> the line completes on the bus, returns to IDLE, and the same address misses again (second MemReq). Flush in IDLE after a fill -> the next fetch misses.
- FetchAddr changed to 0x200 mid-FILL of line 0x100 -> 0x100 line filled; then 0x200 misses and is requested.
- Rst driven low mid-FILL, asynchronously between edges -> MemReq=0 and Imiss=0 immediately. After release, every address misses. MissCount saturates at 0xFFFF under a forced long miss sequence with CNT_W=16.
